// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types, default parameters and helpers for the LC-3b pipeline
// stall controller.
package pipeline_stall_controller_pkg;

  localparam int unsigned RETRY_DELAY_DEF = 32'd2;
  localparam int unsigned MAX_RETRIES_DEF = 32'd8;
  localparam int unsigned CNT_W_DEF       = 32'd4;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_REQ  = 2'd1,
    I_HOLD = 2'd2
  } lc3b_ifetch_state_t;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_REQ     = 2'd1,
    D_BACKOFF = 2'd2,
    D_HOLD    = 2'd3
  } lc3b_dmem_state_t;

  // Next stage-valid vector on an advance. Bit order is [3]=WB .. [0]=ID.
  // A flush kills every stage, including the slot being fetched now.
  // drop_wb kills only the instruction moving from MEM into WB.
  function automatic logic [3:0] shift_valids(input logic [3:0] cur,
                                              input logic       flush,
                                              input logic       drop_wb);
    logic [3:0] nxt;
    if (flush) begin
      nxt = 4'b0000;
    end else begin
      nxt = {cur[2] & ~drop_wb, cur[1], cur[0], 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Instruction and data cache handshake bundle. The controller is the
// master (drives stb/cyc); the caches are the slave side.
interface pipeline_stall_controller_if;

  logic imem_action_stb;
  logic imem_action_cyc;
  logic imem_resp;
  logic dmem_action_stb;
  logic dmem_action_cyc;
  logic dmem_resp;
  logic dmem_retry;

  modport master (
    output imem_action_stb,
    output imem_action_cyc,
    input  imem_resp,
    output dmem_action_stb,
    output dmem_action_cyc,
    input  dmem_resp,
    input  dmem_retry
  );

  modport slave (
    input  imem_action_stb,
    input  imem_action_cyc,
    output imem_resp,
    input  dmem_action_stb,
    input  dmem_action_cyc,
    output dmem_resp,
    output dmem_retry
  );

endinterface

// File: rtl/pipeline_stall_controller_dmem_retry_fsm.sv
// Data-memory access sequencer: strobes the data cache, backs off on retry,
// gives up after MAX_RETRIES (sticky error) and reports completion.
module dmem_retry_fsm
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned RETRY_DELAY = RETRY_DELAY_DEF,
  parameter int unsigned MAX_RETRIES = MAX_RETRIES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic resp,
  input  logic retry,
  input  logic advance,
  output logic stb,
  output logic cyc,
  output logic done,
  output logic abort,
  output logic error
);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(RETRY_DELAY);
  localparam logic [CNT_W-1:0] RETRY_MAX  = CNT_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  lc3b_dmem_state_t state;
  logic [CNT_W-1:0] backoff_cnt;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] retry_cnt_inc;

  assign retry_cnt_inc = retry_cnt + CNT_ONE;

  // A response wins over a simultaneous retry; an aborted access completes from D_HOLD.
  assign done = ((state == D_REQ) & resp) | (state == D_HOLD);

  // Data FSM with registered stb/cyc, back-off and retry counters, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= D_IDLE;
      stb         <= 1'b0;
      cyc         <= 1'b0;
      backoff_cnt <= CNT_ZERO;
      retry_cnt   <= CNT_ZERO;
      abort       <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        D_IDLE: begin
          if (start) begin
            state <= D_REQ;
            stb   <= 1'b1;
            cyc   <= 1'b1;
          end else begin
            stb <= 1'b0;
            cyc <= 1'b0;
          end
        end
        D_REQ: begin
          if (resp) begin
            state <= advance ? D_IDLE : D_HOLD;
            stb   <= 1'b0;
            cyc   <= 1'b0;
          end else if (retry) begin
            retry_cnt <= retry_cnt_inc;
            if (retry_cnt_inc >= RETRY_MAX) begin
              state <= D_HOLD;
              stb   <= 1'b0;
              cyc   <= 1'b0;
              abort <= 1'b1;
              error <= 1'b1;
            end else begin
              state       <= D_BACKOFF;
              stb         <= 1'b0;
              cyc         <= 1'b1;
              backoff_cnt <= DELAY_LOAD;
            end
          end else begin
            stb <= 1'b1;
            cyc <= 1'b1;
          end
        end
        D_BACKOFF: begin
          // Leave on the last back-off cycle so stb stays low for exactly RETRY_DELAY cycles.
          if (backoff_cnt <= CNT_ONE) begin
            state       <= D_REQ;
            stb         <= 1'b1;
            cyc         <= 1'b1;
            backoff_cnt <= CNT_ZERO;
          end else begin
            backoff_cnt <= backoff_cnt - CNT_ONE;
          end
        end
        D_HOLD: begin
          if (advance) begin
            state <= D_IDLE;
            abort <= 1'b0;
          end else begin
            state <= D_HOLD;
          end
        end
        default: begin
          state <= D_IDLE;
          stb   <= 1'b0;
          cyc   <= 1'b0;
          abort <= 1'b0;
        end
      endcase
      if (advance) begin
        retry_cnt <= CNT_ZERO;
      end
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Sequences the 5-stage LC-3b pipeline: instruction fetch handshake,
// lock-step stage loads, per-stage valid bits and branch flush.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned RETRY_DELAY = RETRY_DELAY_DEF,
  parameter int unsigned MAX_RETRIES = MAX_RETRIES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  pipeline_stall_controller_if.master        bus,
  input  logic                               mem_access,
  input  logic                               branch_enable,
  output logic                               load_if_id,
  output logic                               load_id_ex,
  output logic                               load_ex_mem,
  output logic                               load_mem_wb,
  output logic                               valid_id,
  output logic                               valid_ex,
  output logic                               valid_mem,
  output logic                               valid_wb,
  output logic                               dmem_error
);

  lc3b_ifetch_state_t istate;
  logic       imem_req;
  logic       imem_done;
  logic       mem_need;
  logic       dmem_done;
  logic       dmem_abort;
  logic       dmem_stb;
  logic       dmem_cyc;
  logic       advance;
  logic       flush;
  logic [3:0] valids;

  assign imem_done = ((istate == I_REQ) & bus.imem_resp) | (istate == I_HOLD);
  assign mem_need  = valids[2] & mem_access;
  assign advance   = imem_done & (~mem_need | dmem_done);
  assign flush     = branch_enable & valids[3] & advance;

  // Loads follow advance combinationally so a zero-wait response moves the pipe that cycle.
  assign load_if_id  = advance;
  assign load_id_ex  = advance;
  assign load_ex_mem = advance;
  assign load_mem_wb = advance;

  assign bus.imem_action_stb = imem_req;
  assign bus.imem_action_cyc = imem_req;
  assign bus.dmem_action_stb = dmem_stb;
  assign bus.dmem_action_cyc = dmem_cyc;

  assign valid_id  = valids[0];
  assign valid_ex  = valids[1];
  assign valid_mem = valids[2];
  assign valid_wb  = valids[3];

  // Instruction fetch FSM; stb/cyc are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      istate   <= I_IDLE;
      imem_req <= 1'b0;
    end else begin
      case (istate)
        I_IDLE: begin
          istate   <= I_REQ;
          imem_req <= 1'b1;
        end
        I_REQ: begin
          if (advance) begin
            istate   <= I_IDLE;
            imem_req <= 1'b0;
          end else if (bus.imem_resp) begin
            istate   <= I_HOLD;
            imem_req <= 1'b0;
          end else begin
            imem_req <= 1'b1;
          end
        end
        I_HOLD: begin
          if (advance) begin
            istate <= I_IDLE;
          end else begin
            istate <= I_HOLD;
          end
          imem_req <= 1'b0;
        end
        default: begin
          istate   <= I_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Stage valid bits shift on advance; flush or a retry abort kill wrong/failed work.
  always_ff @(posedge clk) begin
    if (reset) begin
      valids <= 4'b0000;
    end else if (advance) begin
      valids <= shift_valids(valids, flush, dmem_abort);
    end else begin
      valids <= valids;
    end
  end

  dmem_retry_fsm #(
    .RETRY_DELAY (RETRY_DELAY),
    .MAX_RETRIES (MAX_RETRIES),
    .CNT_W       (CNT_W)
  ) u_dmem (
    .clk     (clk),
    .reset   (reset),
    .start   (mem_need),
    .resp    (bus.dmem_resp),
    .retry   (bus.dmem_retry),
    .advance (advance),
    .stb     (dmem_stb),
    .cyc     (dmem_cyc),
    .done    (dmem_done),
    .abort   (dmem_abort),
    .error   (dmem_error)
  );

endmodule
